// File: rtl/ifmap_rd_pkg.sv
// ifmap_rd_pkg: shared constants and FSM state type for the ifmap read sequencer.
// Optional feature macro used by the block: IFMAP_RD_REPEAT_EN (multi-pass replay).
package ifmap_rd_pkg;

    localparam int unsigned IFMAP_DEPTH  = 128;
    localparam int unsigned IFMAP_ADDR_W = 7;
    localparam int unsigned IFMAP_DATA_W = 8;
    localparam int unsigned IFMAP_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ifmap_rd_skid.sv
// ifmap_rd_skid: 2-entry FIFO of {data, last} feeding the MAC-array stream.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push/push_data/push_last  write side (no full check; caller guarantees room)
//   valid/ready/data/last     read side, valid/ready handshake
//   count                 current occupancy (0..2)
module ifmap_rd_skid
    import ifmap_rd_pkg::*;
#(
    parameter int unsigned DATA_W = IFMAP_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_data [2];
    logic [1:0]        mem_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count_q;
    logic              pop;

    assign valid = (count_q != 2'd0);
    assign pop   = valid & ready;
    assign data  = mem_data[rd_ptr];
    assign last  = mem_last[rd_ptr];
    assign count = count_q;

    // Storage, pointers and occupancy; head entry is stable until popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/ifmap_rd_ctrl.sv
// ifmap_rd_ctrl: read sequencer for the 128x8 ifmap buffer. Walks addresses
// 0..len-1 per pass, absorbs the buffer's 1-cycle read latency and streams bytes
// to the MAC array over valid/ready. Macro IFMAP_RD_REPEAT_EN enables multi-pass
// replay (repeat_i passes); without it exactly one pass runs.
// Ports:
//   start_i, len_i, repeat_i   job request (sampled on start_i)
//   busy_o, done_o             job status
//   buf_rden_o, buf_addr_o, buf_data_i   buffer read port
//   ifmap_valid_o/ready_i/data_o/last_o  output stream
module ifmap_rd_ctrl
    import ifmap_rd_pkg::*;
#(
    parameter int unsigned DEPTH  = IFMAP_DEPTH,
    parameter int unsigned DATA_W = IFMAP_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [7:0]              len_i,
    input  logic [7:0]              repeat_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    buf_rden_o,
    output logic [IFMAP_ADDR_W-1:0] buf_addr_o,
    input  logic [DATA_W-1:0]       buf_data_i,
    output logic                    ifmap_valid_o,
    input  logic                    ifmap_ready_i,
    output logic [DATA_W-1:0]       ifmap_data_o,
    output logic                    ifmap_last_o
);

    localparam int unsigned CW = IFMAP_CNT_W;

    rd_state_t               state_q;
    rd_state_t               state_d;
    logic [CW-1:0]           len_q;
    logic [CW-1:0]           len_sat;
    logic [IFMAP_ADDR_W-1:0] addr_cnt_q;
    logic [IFMAP_ADDR_W-1:0] addr_hold_q;
    logic                    rden_q;
    logic                    last_q;
    logic                    busy_q;
    logic                    null_done_q;
    logic                    rden_c;
    logic                    done_c;
    logic                    pop;
    logic                    addr_last;
    logic                    pass_last;
    logic                    start_ok;
    logic                    start_nz;
    logic [1:0]              fifo_count;
    logic [2:0]              occ;

    assign len_sat   = (len_i > CW'(DEPTH)) ? CW'(DEPTH) : len_i;
    assign start_ok  = start_i && (state_q == IDLE) && !null_done_q;
    assign start_nz  = (len_i != 8'd0) && (repeat_i != 8'd0);
    assign addr_last = (CW'(addr_cnt_q) == (len_q - CW'(1)));
    assign pop       = ifmap_valid_o & ifmap_ready_i;
    // Entries held plus the read still in flight; must stay below 2 after this cycle's pop.
    assign occ       = 3'(fifo_count) + 3'(rden_q);

`ifdef IFMAP_RD_REPEAT_EN
    logic [CW-1:0] rep_q;
    logic [CW-1:0] pass_cnt_q;

    assign pass_last = (pass_cnt_q == (rep_q - CW'(1)));

    // Pass counter: advances each time the address counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q      <= '0;
            pass_cnt_q <= '0;
        end else if (start_ok) begin
            rep_q      <= repeat_i;
            pass_cnt_q <= '0;
        end else if (rden_c && addr_last) begin
            pass_cnt_q <= pass_cnt_q + CW'(1);
        end
    end
`else
    assign pass_last = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue and completion.
    always_comb begin
        state_d = state_q;
        rden_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok && start_nz) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rden_c = (occ < (3'd2 + 3'(pop)));
                if (rden_c && addr_last && pass_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !rden_q) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job parameters, address counter and read-tracking flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            addr_cnt_q  <= '0;
            addr_hold_q <= '0;
            rden_q      <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            null_done_q <= 1'b0;
        end else begin
            rden_q      <= rden_c;
            last_q      <= rden_c & addr_last;
            busy_q      <= (state_d != IDLE);
            null_done_q <= start_ok && !start_nz;
            if (start_ok) begin
                len_q      <= len_sat;
                addr_cnt_q <= '0;
            end else if (rden_c) begin
                addr_cnt_q <= addr_last ? '0 : (addr_cnt_q + IFMAP_ADDR_W'(1));
            end
            // Remember the last issued address; park at 0 once idle.
            if (state_d == IDLE) begin
                addr_hold_q <= '0;
            end else if (rden_c) begin
                addr_hold_q <= addr_cnt_q;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_c | null_done_q;
    assign buf_rden_o = rden_c;
    assign buf_addr_o = rden_c ? addr_cnt_q : addr_hold_q;

    // Returned read data lands in the FIFO one cycle after issue.
    ifmap_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rden_q),
        .push_data (buf_data_i),
        .push_last (last_q),
        .valid     (ifmap_valid_o),
        .ready     (ifmap_ready_i),
        .data      (ifmap_data_o),
        .last      (ifmap_last_o),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ifmap_rd_ctrl.sv
module tb_ifmap_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [7:0] len_i;
    logic [7:0] repeat_i;
    logic       busy_o;
    logic       done_o;
    logic       buf_rden_o;
    logic [6:0] buf_addr_o;
    logic [7:0] buf_data_i;
    logic       ifmap_valid_o;
    logic       ifmap_ready_i;
    logic [7:0] ifmap_data_o;
    logic       ifmap_last_o;

    int checks = 0;
    int errors = 0;
    int rdy_pct = 100;

    logic [7:0] mem [128];

    // Behavioural model state: counts of reads issued and beats accepted.
    int m_busy, m_null, m_issued, m_acc, m_prev, m_last_addr, m_total, m_len;
    int obs_reads, obs_beats;

    ifmap_rd_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .len_i         (len_i),
        .repeat_i      (repeat_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .buf_rden_o    (buf_rden_o),
        .buf_addr_o    (buf_addr_o),
        .buf_data_i    (buf_data_i),
        .ifmap_valid_o (ifmap_valid_o),
        .ifmap_ready_i (ifmap_ready_i),
        .ifmap_data_o  (ifmap_data_o),
        .ifmap_last_o  (ifmap_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer with one-cycle registered read.
    always @(posedge clk) begin
        if (buf_rden_o) buf_data_i <= mem[buf_addr_o];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Negedge half: compare DUT against the model, then advance the model for the next edge.
    task automatic half_a();
        int e_valid, e_pop, e_rden, e_addr, e_done, idx, was_busy, was_null, lsat;
        @(negedge clk);
        if (!rst_n) begin
            m_busy = 0; m_null = 0; m_issued = 0; m_acc = 0; m_prev = 0;
            m_last_addr = 0; m_total = 0; m_len = 1;
        end else begin
            if (buf_rden_o) obs_reads++;
            if (ifmap_valid_o && ifmap_ready_i) obs_beats++;
            e_valid = (m_busy != 0 && (m_issued - m_prev - m_acc) > 0) ? 1 : 0;
            e_pop   = (e_valid != 0 && ifmap_ready_i) ? 1 : 0;
            e_rden  = (m_busy != 0 && m_issued < m_total && (m_issued - m_acc - e_pop) < 2) ? 1 : 0;
            e_addr  = (e_rden != 0) ? (m_issued % m_len) : ((m_busy != 0) ? m_last_addr : 0);
            e_done  = ((m_busy != 0 && m_acc == m_total) || m_null != 0) ? 1 : 0;
            chk("busy", int'(busy_o), m_busy);
            chk("done", int'(done_o), e_done);
            chk("rden", int'(buf_rden_o), e_rden);
            chk("addr", int'(buf_addr_o), e_addr);
            chk("valid", int'(ifmap_valid_o), e_valid);
            if (e_valid != 0) begin
                idx = m_acc % m_len;
                chk("data", int'(ifmap_data_o), int'(mem[idx[6:0]]));
                chk("last", int'(ifmap_last_o), (idx == m_len - 1) ? 1 : 0);
            end
            was_busy = m_busy;
            was_null = m_null;
            if (m_busy != 0 && m_acc == m_total) m_busy = 0;
            if (e_rden != 0) m_last_addr = m_issued % m_len;
            m_issued += e_rden;
            m_acc    += e_pop;
            m_prev    = e_rden;
            m_null    = 0;
            if (start_i && was_busy == 0 && was_null == 0) begin
                if (len_i == 8'd0 || repeat_i == 8'd0) begin
                    m_null = 1;
                end else begin
                    lsat = (int'(len_i) > 128) ? 128 : int'(len_i);
                    m_busy = 1; m_len = lsat; m_issued = 0; m_acc = 0; m_prev = 0;
`ifdef IFMAP_RD_REPEAT_EN
                    m_total = lsat * int'(repeat_i);
`else
                    m_total = lsat;
`endif
                end
            end
        end
    endtask

    // Posedge half: land just after the edge and drive a fresh ready.
    task automatic half_b();
        @(posedge clk);
        #1;
        ifmap_ready_i = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic do_start(input int len, input int rep);
        start_i  = 1'b1;
        len_i    = 8'(len);
        repeat_i = 8'(rep);
        tick();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int seen = 0;
        for (int i = 0; i < bound && seen == 0; i++) begin
            half_a();
            if (done_o) seen = 1;
            half_b();
        end
        chk(name, seen, 1);
    endtask

    // Directed run with hand-derived cycle expectations (ready held at 1).
    task automatic run_lit(input int len, input int rep, input logic [7:0] base, input int nbeats);
        int k;
        for (int i = 0; i < 128; i++) mem[i] = base + 8'(i);
        rdy_pct = 100;
        do_start(len, rep);
        for (int c = 1; c <= nbeats + 4; c++) begin
            half_a();
            chk("lit_busy", int'(busy_o), (c <= nbeats + 3) ? 1 : 0);
            chk("lit_valid", int'(ifmap_valid_o), (c >= 3 && c <= nbeats + 2) ? 1 : 0);
            chk("lit_done", int'(done_o), (c == nbeats + 3) ? 1 : 0);
            if (c == 1) begin
                chk("lit_rden1", int'(buf_rden_o), 1);
                chk("lit_addr1", int'(buf_addr_o), 0);
            end
            if (c >= 3 && c <= nbeats + 2) begin
                k = (c - 3) % len;
                chk("lit_data", int'(ifmap_data_o), int'(base) + k);
                chk("lit_last", int'(ifmap_last_o), (k == len - 1) ? 1 : 0);
            end
            half_b();
        end
    endtask

    task automatic run_rand(input int len, input int rep, input int pct, input int exp_reads);
        int r0, b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        rdy_pct = pct;
        r0 = obs_reads;
        b0 = obs_beats;
        do_start(len, rep);
        wait_done(20000, "done_timeout");
        tick();
        tick();
        chk("reads_total", obs_reads - r0, exp_reads);
        chk("beats_total", obs_beats - b0, exp_reads);
    endtask

    initial begin
        int len, rep, er, lsat;
        rst_n = 1'b0; start_i = 1'b0; len_i = '0; repeat_i = '0;
        ifmap_ready_i = 1'b1; buf_data_i = '0;
        m_busy = 0; m_null = 0; m_issued = 0; m_acc = 0; m_prev = 0;
        m_last_addr = 0; m_total = 0; m_len = 1; obs_reads = 0; obs_beats = 0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_rden", int'(buf_rden_o), 0);
        chk("rst_addr", int'(buf_addr_o), 0);
        chk("rst_valid", int'(ifmap_valid_o), 0);
        chk("rst_data", int'(ifmap_data_o), 0);
        chk("rst_last", int'(ifmap_last_o), 0);
        rst_n = 1'b1;
        tick();

        // 0x10..0x13 on cycles 3-6, done in cycle 7.
        run_lit(4, 1, 8'h10, 4);
        tick();
`ifdef IFMAP_RD_REPEAT_EN
        run_lit(3, 2, 8'hA0, 6);
`else
        run_lit(3, 2, 8'hA0, 3);
`endif
        tick();

        // Full buffer under random backpressure.
        run_rand(128, 1, 50, 128);
        // Zero-length and zero-repeat requests issue nothing.
        run_rand(0, 1, 100, 0);
        run_rand(5, 0, 100, 0);
        // Oversized length saturates to the buffer depth.
        run_rand(200, 1, 70, 128);

        // Start coinciding with the completion pulse is ignored.
        rdy_pct = 100;
        do_start(2, 1);
        for (int c = 1; c <= 8; c++) begin
            half_a();
            if (c == 5) chk("sd_done", int'(done_o), 1);
            if (c >= 6) chk("sd_busy", int'(busy_o), 0);
            half_b();
            start_i = (c == 4);
            len_i   = 8'd5;
            repeat_i = 8'd1;
        end
        start_i = 1'b0;
        do_start(0, 1);
        start_i = 1'b1; len_i = 8'd3; repeat_i = 8'd1;
        half_a();
        chk("nd_done", int'(done_o), 1);
        half_b();
        start_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half_a();
            chk("nd_busy", int'(busy_o), 0);
            half_b();
        end

        // Randomized jobs.
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 200);
            rep = $urandom_range(0, 3);
            lsat = (len > 128) ? 128 : len;
`ifdef IFMAP_RD_REPEAT_EN
            er = lsat * rep;
`else
            er = (rep == 0) ? 0 : lsat;
`endif
            run_rand(len, rep, $urandom_range(25, 100), er);
        end

        // Async reset in mid-RUN with the stream stalled.
        rdy_pct = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        do_start(100, 1);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", int'(busy_o), 0);
        chk("mr_done", int'(done_o), 0);
        chk("mr_rden", int'(buf_rden_o), 0);
        chk("mr_addr", int'(buf_addr_o), 0);
        chk("mr_valid", int'(ifmap_valid_o), 0);
        chk("mr_data", int'(ifmap_data_o), 0);
        chk("mr_last", int'(ifmap_last_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_lit(4, 1, 8'h10, 4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
